hb_sym_sequencer: RTL and testbench
===================================

Name: hb_sym_sequencer

Overview:
- Sequencer for the 16-entry dual-read summing sample RAM used in our symmetric FIR / halfband decimators.
- Writes each incoming sample into the RAM as a circular buffer and, every second accepted sample (decimate-by-2), issues a read-address sequence: NPAIRS symmetric tap pairs, then the centre tap.
- Drives the downstream MAC with coefficient index, accumulate-enable, accumulate-clear and output strobe, all aligned to the RAM's 2-cycle read-to-sum latency.

Parameters:
- NPAIRS, 7: number of symmetric tap pairs; filter length 2*NPAIRS+1; legal range 1..7.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- enable  in  1  accept input samples when high
- strobe_in  in  1  one-cycle input-sample-valid
- write  out  1  RAM write enable (combinational: strobe_in & enable)
- wr_addr  out  4  RAM write address (= wptr)
- rd_addr1  out  4  RAM read address, newer-side tap
- rd_addr2  out  4  RAM read address, older-side tap
- coeff_idx  out  3  coefficient index aligned with acc_en; 0..NPAIRS
- acc_clear  out  1  first accumulate term of an output
- acc_en  out  1  RAM sum output is a valid MAC term this cycle
- strobe_out  out  1  one-cycle pulse: output sample complete
- busy  out  1  sequence in progress
- overrun  out  1  sticky: output request dropped while busy

Behaviour:
- Reset values (all registered outputs, next edge with reset=1): wptr=0, phase=0, fill count=0, state IDLE, rd_addr1=rd_addr2=0, coeff_idx=0, acc_clear=acc_en=strobe_out=busy=overrun=0.
- Reset mid-sequence aborts immediately: no further acc_en or strobe_out pulses.
- Accept rule: a sample is accepted when strobe_in & enable in cycle 0.
  - write=1, wr_addr=wptr in cycle 0.
  - wptr increments mod 16 at the end of cycle 0.
  - phase toggles.
  - Fill counter increments and saturates at 2*NPAIRS+1.
  - Writes are accepted in any state, including while busy.
- Start condition: an accepted sample with phase=1 (every 2nd accepted sample since reset).
  - Latch base = address just written.
  - The state machine leaves IDLE at the end of cycle 0.
  - If the fill count after this sample is < 2*NPAIRS+1, the sequence runs but strobe_out, acc_en and acc_clear stay 0 (priming).
- States and address issue:
  - IDLE -> PAIR at start.
  - PAIR holds for k=0..NPAIRS-1, one pair per cycle, starting cycle 1: rd_addr1=base-k, rd_addr2=base-2*NPAIRS+k (4-bit wrap).
  - CENTER, 1 cycle: rd_addr1=rd_addr2=base-NPAIRS.
  - DRAIN holds 3 cycles, then -> IDLE.
- Address lists are computed from the latched base only; later writes do not disturb an in-progress sequence.
- MAC alignment: the RAM sum is valid 2 cycles after its address.
  - acc_en=1 on cycles 3..NPAIRS+3.
  - coeff_idx counts 0..NPAIRS on those cycles.
  - acc_clear=1 on cycle 3 only.
  - strobe_out=1 on cycle NPAIRS+4.
  - busy=1 on cycles 1..NPAIRS+4 inclusive.
- Overrun: a start condition while busy=1 (including the strobe_out cycle) is dropped.
  - overrun is set and stays set until reset.
  - The sample is still written and phase still toggles.
- enable=0: strobe_in ignored (no write, no pointer/phase change); an in-progress sequence runs to completion.
- A 5th consecutive-sample read distance of at most 14 behind base guarantees the 1-sample write slack while busy never corrupts the read set at NPAIRS<=7.

Test Plan:
- Reset: hold reset 3 cycles with strobe_in=1 -> write=0 is not required, but all registered outputs are 0 and wptr=0 after release.
- Prime/first output, NPAIRS=7: 16 strobes spaced 20 cycles, data=index.
  - No acc_en for the first 14 samples (starts at samples 2..14 are priming).
  - After the 16th sample (base=15): pairs (15,1),(14,2)…(9,7), then centre (8,8).
  - acc_en 8 cycles, coeff_idx 0..7, strobe_out at cycle 11 after the accept.
- Wrap: continue to base=3 -> first pair (3,5), last pair (13,11), centre (12,12).
- Overrun: strobe_in every cycle for 8 samples -> starts at samples 2,4 (second within busy) dropped; overrun=1 from the 4th accept; wptr=8; only non-dropped sequences strobe.
- Reset mid-sequence: assert reset in cycle 4 of a sequence -> no strobe_out; outputs 0 next cycle; the next start needs 2 new samples and a full re-prime.
- enable=0: 4 strobes with enable low during a sequence -> no write, wptr unchanged; the sequence completes with strobe_out on schedule.

Source files
------------

// File: rtl/hb_sym_sequencer.sv
// Address/control sequencer for the dual-read summing sample RAM of a symmetric
// FIR / halfband decimator: circular write, decimate-by-2 read sequence, MAC strobes.
module hb_sym_sequencer #(
    parameter int NPAIRS = 7
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       strobe_in,
    output logic       write,
    output logic [3:0] wr_addr,
    output logic [3:0] rd_addr1,
    output logic [3:0] rd_addr2,
    output logic [2:0] coeff_idx,
    output logic       acc_clear,
    output logic       acc_en,
    output logic       strobe_out,
    output logic       busy,
    output logic       overrun
);

    localparam logic [3:0] FILL_MAX = 4'(2 * NPAIRS + 1);
    localparam logic [3:0] SPAN     = 4'(2 * NPAIRS);
    localparam logic [3:0] CTR_OFS  = 4'(NPAIRS);
    localparam logic [2:0] LAST_K   = 3'(NPAIRS - 1);
    localparam logic [2:0] CTR_IDX  = 3'(NPAIRS);

    typedef enum logic [1:0] {
        IDLE,
        PAIR,
        CENTER,
        DRAIN
    } state_t;

    state_t     state;
    state_t     state_n;
    logic [2:0] cnt;
    logic [2:0] cnt_n;

    logic [3:0] wptr;
    logic [3:0] base;
    logic [3:0] fill;
    logic [3:0] fill_n;
    logic       phase;
    logic       live;

    logic       accept;
    logic       start;
    logic       drop;

    logic       iss_v;
    logic [2:0] iss_idx;
    logic       p1_v;
    logic [2:0] p1_idx;

    always_comb begin
        accept  = strobe_in & enable;
        start   = accept & phase & (state == IDLE);
        drop    = accept & phase & (state != IDLE);
        fill_n  = (fill == FILL_MAX) ? fill : fill + 4'd1;
        write   = accept;
        wr_addr = wptr;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr    <= '0;
            phase   <= 1'b0;
            fill    <= '0;
            base    <= '0;
            live    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (accept) begin
                wptr  <= wptr + 4'd1;
                phase <= ~phase;
                fill  <= fill_n;
            end
            // Output is only meaningful once a full filter span has been written.
            if (start) begin
                base <= wptr;
                live <= (fill_n == FILL_MAX);
            end
            if (drop) begin
                overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        rd_addr1   = '0;
        rd_addr2   = '0;
        iss_v      = 1'b0;
        iss_idx    = '0;
        strobe_out = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = PAIR;
                    cnt_n   = '0;
                end
            end
            PAIR: begin
                rd_addr1 = base - {1'b0, cnt};
                rd_addr2 = base - SPAN + {1'b0, cnt};
                iss_v    = live;
                iss_idx  = cnt;
                if (cnt == LAST_K) begin
                    state_n = CENTER;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            CENTER: begin
                rd_addr1 = base - CTR_OFS;
                rd_addr2 = base - CTR_OFS;
                iss_v    = live;
                iss_idx  = CTR_IDX;
                state_n  = DRAIN;
                cnt_n    = '0;
            end
            DRAIN: begin
                // Last drain cycle coincides with the final term leaving the MAC.
                if (cnt == 3'd2) begin
                    strobe_out = live;
                    state_n    = IDLE;
                    cnt_n      = '0;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Two-stage delay matches the RAM read-to-sum latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            p1_v      <= 1'b0;
            p1_idx    <= '0;
            acc_en    <= 1'b0;
            coeff_idx <= '0;
            acc_clear <= 1'b0;
        end else begin
            p1_v      <= iss_v;
            p1_idx    <= iss_v ? iss_idx : 3'd0;
            acc_en    <= p1_v;
            coeff_idx <= p1_idx;
            acc_clear <= p1_v && (p1_idx == 3'd0);
        end
    end

endmodule

// File: tb/tb_hb_sym_sequencer.sv
// Self-checking bench for hb_sym_sequencer: absolute-time event schedule model
// plus directed spot checks of the documented address and strobe timing.
module tb_hb_sym_sequencer;

    localparam int N       = 7;
    localparam int FILLMAX = 2 * N + 1;
    localparam int MAXC    = 4096;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       strobe_in;
    logic       write;
    logic [3:0] wr_addr;
    logic [3:0] rd_addr1;
    logic [3:0] rd_addr2;
    logic [2:0] coeff_idx;
    logic       acc_clear;
    logic       acc_en;
    logic       strobe_out;
    logic       busy;
    logic       overrun;

    hb_sym_sequencer #(.NPAIRS(N)) dut (
        .clock(clock), .reset(reset), .enable(enable), .strobe_in(strobe_in),
        .write(write), .wr_addr(wr_addr), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .coeff_idx(coeff_idx), .acc_clear(acc_clear), .acc_en(acc_en),
        .strobe_out(strobe_out), .busy(busy), .overrun(overrun)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Packed layout: write, wr_addr, rd1, rd2, coeff, clear, acc_en, strobe, busy, overrun
    logic [20:0] o_vec [MAXC];
    logic [20:0] e_vec [MAXC];
    logic [20:0] e_mask[MAXC];

    bit       ex_busy[MAXC];
    bit       ex_acc [MAXC];
    bit       ex_clr [MAXC];
    bit       ex_stb [MAXC];
    bit       ex_rdv [MAXC];
    logic [3:0] ex_rd1[MAXC];
    logic [3:0] ex_rd2[MAXC];
    logic [2:0] ex_coef[MAXC];

    int m_wptr     = 0;
    int m_phase    = 0;
    int m_fill     = 0;
    int m_busy_end = -1;
    bit m_ovr      = 1'b0;
    bit armed      = 1'b0;
    int last_acc   = 0;

    task automatic step(input logic r, input logic e, input logic s);
        logic [20:0] mask;
        int base;
        reset     = r;
        enable    = e;
        strobe_in = s;
        @(negedge clock);
        if (cyc >= MAXC) begin
            failures++;
            $display("FAIL cycle_budget got=%0d limit=%0d", cyc, MAXC);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "cycle budget exhausted");
        end
        o_vec[cyc] = {write, wr_addr, rd_addr1, rd_addr2, coeff_idx,
                      acc_clear, acc_en, strobe_out, busy, overrun};
        mask = '1;
        if (!ex_rdv[cyc]) mask[15:8] = '0;
        if (!ex_acc[cyc]) mask[7:5] = '0;
        if (!armed) mask = '0;
        e_mask[cyc] = mask;
        e_vec[cyc]  = {e & s, 4'(m_wptr), ex_rd1[cyc], ex_rd2[cyc], ex_coef[cyc],
                       ex_clr[cyc], ex_acc[cyc], ex_stb[cyc], ex_busy[cyc], m_ovr} & mask;

        if (r) begin
            m_wptr = 0; m_phase = 0; m_fill = 0; m_busy_end = -1; m_ovr = 1'b0;
            armed = 1'b1;
            for (int i = cyc + 1; i < MAXC && i <= cyc + N + 6; i++) begin
                ex_busy[i] = 0; ex_acc[i] = 0; ex_clr[i] = 0; ex_stb[i] = 0; ex_rdv[i] = 0;
            end
        end else if (e && s) begin
            base     = m_wptr;
            last_acc = cyc;
            m_wptr   = (m_wptr + 1) % 16;
            m_fill   = (m_fill < FILLMAX) ? m_fill + 1 : FILLMAX;
            if (m_phase == 1) begin
                if (cyc <= m_busy_end) begin
                    m_ovr = 1'b1;
                end else begin
                    m_busy_end = cyc + N + 4;
                    for (int k = 1; k <= N + 4; k++)
                        if (cyc + k < MAXC) ex_busy[cyc + k] = 1;
                    for (int k = 0; k < N; k++) begin
                        if (cyc + 1 + k < MAXC) begin
                            ex_rdv[cyc + 1 + k] = 1;
                            ex_rd1[cyc + 1 + k] = 4'((base - k + 32) % 16);
                            ex_rd2[cyc + 1 + k] = 4'((base - 2 * N + k + 32) % 16);
                        end
                    end
                    if (cyc + N + 1 < MAXC) begin
                        ex_rdv[cyc + N + 1] = 1;
                        ex_rd1[cyc + N + 1] = 4'((base - N + 32) % 16);
                        ex_rd2[cyc + N + 1] = 4'((base - N + 32) % 16);
                    end
                    if (m_fill == FILLMAX && cyc + N + 4 < MAXC) begin
                        for (int j = 0; j <= N; j++) begin
                            ex_acc[cyc + 3 + j]  = 1;
                            ex_coef[cyc + 3 + j] = 3'(j);
                        end
                        ex_clr[cyc + 3]     = 1;
                        ex_stb[cyc + N + 4] = 1;
                    end
                end
            end
            m_phase = m_phase ^ 1;
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset;
        int c0;
        c0 = cyc;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        idle(2);
        checks++;
        if (o_vec[c0 + 3] !== 21'd0) begin
            failures++;
            $display("FAIL reset_state got=%h expected=%h", o_vec[c0 + 3], 21'd0);
        end
        for (int c = c0; c < cyc; c++) if (e_mask[c] != '0) begin
            checks++;
            if ((o_vec[c] & e_mask[c]) !== e_vec[c]) begin
                failures++;
                $display("FAIL reset cycle=%0d got=%h expected=%h", c, o_vec[c], e_vec[c]);
            end
        end
    endtask

    task automatic test_prime;
        int c0, a, n_acc_pre, n_acc;
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b1);
            idle(19);
            if (i == 15) a = last_acc;
        end
        n_acc_pre = 0; n_acc = 0;
        for (int c = c0; c < a; c++) n_acc_pre += int'(o_vec[c][3]);
        for (int c = a; c < a + 20; c++) n_acc += int'(o_vec[c][3]);
        checks++;
        if (n_acc_pre !== 0) begin
            failures++; $display("FAIL prime_no_acc got=%0d expected=0", n_acc_pre);
        end
        checks++;
        if (n_acc !== 8) begin
            failures++; $display("FAIL first_acc_count got=%0d expected=8", n_acc);
        end
        checks++;
        if (o_vec[a + 1][15:8] !== 8'hF1) begin
            failures++; $display("FAIL first_pair got=%h expected=f1", o_vec[a + 1][15:8]);
        end
        checks++;
        if (o_vec[a + 7][15:8] !== 8'h97) begin
            failures++; $display("FAIL last_pair got=%h expected=97", o_vec[a + 7][15:8]);
        end
        checks++;
        if (o_vec[a + 8][15:8] !== 8'h88) begin
            failures++; $display("FAIL centre got=%h expected=88", o_vec[a + 8][15:8]);
        end
        checks++;
        if (o_vec[a + 11][2] !== 1'b1 || o_vec[a + 10][2] !== 1'b0) begin
            failures++; $display("FAIL strobe_timing got=%b%b expected=01", o_vec[a + 10][2], o_vec[a + 11][2]);
        end
        for (int c = c0; c < cyc; c++) if (e_mask[c] != '0) begin
            checks++;
            if ((o_vec[c] & e_mask[c]) !== e_vec[c]) begin
                failures++;
                $display("FAIL prime cycle=%0d got=%h expected=%h", c, o_vec[c], e_vec[c]);
            end
        end
    endtask

    task automatic test_wrap;
        int c0, a;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1);
            idle(19);
            if (i == 3) a = last_acc;
        end
        checks++;
        if (o_vec[a + 1][15:8] !== 8'h35) begin
            failures++; $display("FAIL wrap_first_pair got=%h expected=35", o_vec[a + 1][15:8]);
        end
        checks++;
        if (o_vec[a + 7][15:8] !== 8'hDB) begin
            failures++; $display("FAIL wrap_last_pair got=%h expected=db", o_vec[a + 7][15:8]);
        end
        checks++;
        if (o_vec[a + 8][15:8] !== 8'hCC) begin
            failures++; $display("FAIL wrap_centre got=%h expected=cc", o_vec[a + 8][15:8]);
        end
        checks++;
        if (o_vec[a + 10][7:5] !== 3'd7 || o_vec[a + 3][4] !== 1'b1) begin
            failures++; $display("FAIL wrap_coeff got=%0d/%b expected=7/1", o_vec[a + 10][7:5], o_vec[a + 3][4]);
        end
        for (int c = c0; c < cyc; c++) if (e_mask[c] != '0) begin
            checks++;
            if ((o_vec[c] & e_mask[c]) !== e_vec[c]) begin
                failures++;
                $display("FAIL wrap cycle=%0d got=%h expected=%h", c, o_vec[c], e_vec[c]);
            end
        end
    endtask

    task automatic test_overrun;
        int c0, acc4, b0, n_stb;
        c0 = cyc;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1);
            if (i == 3) acc4 = last_acc;
        end
        idle(15);
        checks++;
        if (o_vec[acc4][0] !== 1'b0 || o_vec[acc4 + 1][0] !== 1'b1) begin
            failures++; $display("FAIL overrun_set got=%b%b expected=01", o_vec[acc4][0], o_vec[acc4 + 1][0]);
        end
        checks++;
        if (o_vec[cyc - 1][19:16] !== 4'd8) begin
            failures++; $display("FAIL overrun_wptr got=%0d expected=8", o_vec[cyc - 1][19:16]);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1);
            idle(19);
        end
        b0 = cyc;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1);
        idle(20);
        n_stb = 0;
        for (int c = b0; c < cyc; c++) n_stb += int'(o_vec[c][2]);
        checks++;
        if (n_stb !== 1) begin
            failures++; $display("FAIL overrun_strobes got=%0d expected=1", n_stb);
        end
        for (int c = c0; c < cyc; c++) if (e_mask[c] != '0) begin
            checks++;
            if ((o_vec[c] & e_mask[c]) !== e_vec[c]) begin
                failures++;
                $display("FAIL overrun cycle=%0d got=%h expected=%h", c, o_vec[c], e_vec[c]);
            end
        end
    endtask

    task automatic test_reset_mid;
        int c0, t, n_stb, n_acc, c1;
        c0 = cyc;
        step(1'b0, 1'b1, 1'b1);
        idle(2);
        step(1'b0, 1'b1, 1'b1);
        t = last_acc;
        idle(3);
        step(1'b1, 1'b0, 1'b0);
        idle(16);
        n_stb = 0;
        for (int c = t; c < cyc; c++) n_stb += int'(o_vec[c][2]);
        checks++;
        if (n_stb !== 0) begin
            failures++; $display("FAIL mid_reset_strobe got=%0d expected=0", n_stb);
        end
        checks++;
        if (o_vec[t + 4][3] !== 1'b1 || o_vec[t + 5][4:0] !== 5'd0) begin
            failures++; $display("FAIL mid_reset_clear got=%b/%h expected=1/00", o_vec[t + 4][3], o_vec[t + 5][4:0]);
        end
        c1 = cyc;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b1);
            idle(19);
        end
        n_acc = 0;
        for (int c = c1; c < cyc; c++) n_acc += int'(o_vec[c][3]);
        checks++;
        if (n_acc !== 0 || o_vec[last_acc + 1][1] !== 1'b1) begin
            failures++; $display("FAIL reprime got=%0d/%b expected=0/1", n_acc, o_vec[last_acc + 1][1]);
        end
        for (int c = c0; c < cyc; c++) if (e_mask[c] != '0) begin
            checks++;
            if ((o_vec[c] & e_mask[c]) !== e_vec[c]) begin
                failures++;
                $display("FAIL reset_mid cycle=%0d got=%h expected=%h", c, o_vec[c], e_vec[c]);
            end
        end
    endtask

    task automatic test_enable;
        int c0, t, wp;
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 1'b1);
            idle(13);
        end
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        t  = last_acc;
        wp = m_wptr;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        idle(16);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (o_vec[t + k][20:16] !== {1'b0, 4'(wp)}) begin
                failures++;
                $display("FAIL enable_low_write got=%h expected=%h", o_vec[t + k][20:16], {1'b0, 4'(wp)});
            end
        end
        checks++;
        if (o_vec[t + N + 4][2] !== 1'b1) begin
            failures++; $display("FAIL enable_low_strobe got=%b expected=1", o_vec[t + N + 4][2]);
        end
        for (int c = c0; c < cyc; c++) if (e_mask[c] != '0) begin
            checks++;
            if ((o_vec[c] & e_mask[c]) !== e_vec[c]) begin
                failures++;
                $display("FAIL enable cycle=%0d got=%h expected=%h", c, o_vec[c], e_vec[c]);
            end
        end
    endtask

    task automatic test_random;
        int c0;
        logic r, e, s;
        c0 = cyc;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 2) == 0);
            step(r, e, s);
        end
        idle(20);
        for (int c = c0; c < cyc; c++) if (e_mask[c] != '0) begin
            checks++;
            if ((o_vec[c] & e_mask[c]) !== e_vec[c]) begin
                failures++;
                $display("FAIL random cycle=%0d got=%h expected=%h", c, o_vec[c], e_vec[c]);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        strobe_in = 1'b0;
        test_reset();
        test_prime();
        test_wrap();
        test_overrun();
        test_reset_mid();
        test_enable();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
